// File: rtl/iod_delay_ctrl.sv
// IOD delay-line tap controller: accepts an absolute target tap, optionally reloads
// the line, then steps it one tap at a time with a settle pause after every pulse.
module iod_delay_ctrl #(
    parameter int TAP_W    = 8,
    parameter int MAX_TAP  = 255,
    parameter int LOAD_TAP = 1,
    parameter int PACE     = 4
) (
    input  logic             FAB_CLK,
    input  logic             ARST_N,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic             REQ_LOAD,
    input  logic [TAP_W-1:0] REQ_TAP,
    input  logic             DELAY_LINE_OUT_OF_RANGE,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    output logic             DELAY_LINE_LOAD,
    output logic [TAP_W-1:0] CUR_TAP,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    input  logic             ERR_CLR
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETUP, S_MOVE, S_WAIT, S_FIN
    } state_t;

    localparam logic [TAP_W-1:0] MAX_T   = TAP_W'(MAX_TAP);
    localparam logic [TAP_W-1:0] LOAD_T  = TAP_W'(LOAD_TAP);
    localparam logic [TAP_W-1:0] ONE_T   = TAP_W'(1);
    localparam logic [3:0]       PACE_M1 = 4'(PACE - 1);

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    state_t           r_state;
    state_t           w_next_state;
    logic [TAP_W-1:0] r_target;
    logic [TAP_W-1:0] r_cur_tap;
    logic             r_dir;
    logic             r_after_move;
    logic [3:0]       r_wait_cnt;
    logic             r_err;
    logic             w_accept;
    logic [TAP_W-1:0] w_req_tgt;
    logic             w_wait_last;
    logic             w_oor_hit;
    logic             w_dir;

    // NOTE: assertion is asynchronous, release is re-timed through two flops so every
    // state flop leaves reset on the same clock edge.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) r_rst_sync <= 2'b00;
        else         r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign REQ_READY   = (r_state == S_IDLE) && !r_err && w_rst_n;
    assign w_accept    = REQ_VALID && REQ_READY;
    assign w_req_tgt   = (REQ_TAP > MAX_T) ? MAX_T : REQ_TAP;
    assign w_wait_last = (r_state == S_WAIT) && (r_wait_cnt == 4'd0);
    assign w_oor_hit   = w_wait_last && r_after_move && DELAY_LINE_OUT_OF_RANGE;
    // Direction is decided while in SETUP and frozen in r_dir for the following MOVE.
    assign w_dir       = (r_state == S_SETUP) ? (r_target > r_cur_tap) : r_dir;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (REQ_LOAD)                    w_next_state = S_LOAD;
                    else if (w_req_tgt == r_cur_tap) w_next_state = S_FIN;
                    else                             w_next_state = S_SETUP;
                end
            end
            S_LOAD:  w_next_state = S_WAIT;
            S_SETUP: w_next_state = S_MOVE;
            S_MOVE:  w_next_state = S_WAIT;
            S_WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    if (w_oor_hit || (r_cur_tap == r_target)) w_next_state = S_FIN;
                    else                                      w_next_state = S_SETUP;
                end
            end
            S_FIN:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge FAB_CLK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state      <= S_IDLE;
            r_target     <= LOAD_T;
            r_cur_tap    <= LOAD_T;
            r_dir        <= 1'b0;
            r_after_move <= 1'b0;
            r_wait_cnt   <= 4'd0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) r_target <= w_req_tgt;
            case (r_state)
                S_LOAD: begin
                    r_cur_tap    <= LOAD_T;
                    r_after_move <= 1'b0;
                    r_wait_cnt   <= PACE_M1;
                end
                S_SETUP: r_dir <= w_dir;
                S_MOVE: begin
                    if (r_dir) begin
                        if (r_cur_tap != MAX_T) r_cur_tap <= r_cur_tap + ONE_T;
                    end else if (r_cur_tap != '0) begin
                        r_cur_tap <= r_cur_tap - ONE_T;
                    end
                    r_after_move <= 1'b1;
                    r_wait_cnt   <= PACE_M1;
                end
                S_WAIT: begin
                    if (r_wait_cnt != 4'd0) r_wait_cnt <= r_wait_cnt - 4'd1;
                    // The IOD refused the last step: undo it in the tracked tap.
                    if (w_oor_hit) r_cur_tap <= r_dir ? (r_cur_tap - ONE_T) : (r_cur_tap + ONE_T);
                end
                default: ;
            endcase
            if (w_oor_hit)    r_err <= 1'b1;
            else if (ERR_CLR) r_err <= 1'b0;
        end
    end

    assign DELAY_LINE_MOVE      = (r_state == S_MOVE);
    assign DELAY_LINE_LOAD      = (r_state == S_LOAD);
    assign DELAY_LINE_DIRECTION = w_dir;
    assign CUR_TAP              = r_cur_tap;
    assign BUSY                 = (r_state != S_IDLE);
    assign DONE                 = (r_state == S_FIN);
    assign ERR                  = r_err;

endmodule
